pipe_stall_ctrl: RTL

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_if.sv | 41 ++++
 rtl/pipe_stall_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if -- hazard/stall handshake bundle between the pipeline datapath and
// pipe_stall_ctrl.
//   master (datapath side): drives hazard/branch/memory status, receives stage control.
//   slave  (controller)   : the reverse.
// Signals:
//   id_rs, id_rt     source register fields of the instruction in ID
//   ex_memread       EX instruction is a load
//   ex_rd            EX destination register
//   ex_branch_taken  branch/jump resolved taken in EX
//   mem_req          MEM stage is doing a load or store
//   mem_ready        data memory completes the access this cycle
//   pc_en .. exmem_en                    stage-register load enables
//   ifid_flush, idex_flush, memwb_bubble NOP insertion / control zeroing
//   mem_err          sticky memory-timeout error
interface pipe_stall_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       ex_memread;
   logic [4:0] ex_rd;
   logic       ex_branch_taken;
   logic       mem_req;
   logic       mem_ready;
   logic       pc_en;
   logic       ifid_en;
   logic       idex_en;
   logic       exmem_en;
   logic       ifid_flush;
   logic       idex_flush;
   logic       memwb_bubble;
   logic       mem_err;

   modport master (
      output id_rs, id_rt, ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_err
   );

   modport slave (
      input  id_rs, id_rt, ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_err
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl -- pipeline stall/flush controller.
// Resolves memory wait stalls, taken-branch flushes and load-use hazards, in that priority,
// and raises a sticky error when a memory access waits longer than MEM_TIMEOUT cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pipe_stall_ctrl_if.slave handshake bundle (see the interface file)
// Optional feature, enabled by defining STALL_PERF_EN:
//   stall_cycles  16-bit saturating count of non-reset cycles with pc_en=0
//   flush_count   16-bit saturating count of non-reset cycles with ifid_flush=1
module pipe_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipe_stall_ctrl_if.slave     bus
`ifdef STALL_PERF_EN
   ,
   output logic [15:0]          stall_cycles,
   output logic [15:0]          flush_count
`endif
);

   localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

   typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

   state_e     state_q;
   logic [7:0] timer_q;
   logic       mem_err_q;

   logic hazard;
   logic mem_stall;
   logic pc_en, ifid_en, idex_en, exmem_en;
   logic ifid_flush, idex_flush, memwb_bubble;

   always_comb begin
      hazard = bus.ex_memread && (bus.ex_rd != 5'd0) &&
               ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));
      // In MEM_WAIT the wait persists on !mem_ready regardless of mem_req.
      mem_stall = !bus.mem_ready && (bus.mem_req || (state_q == StMemWait));

      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;

      if (!rst_n) begin
         {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
         {ifid_flush, idex_flush, memwb_bubble} = 3'b111;
      end else begin
         case (state_q)
            StRun: begin
               if (mem_stall) begin
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                  memwb_bubble = 1'b1;
               end else if (bus.ex_branch_taken) begin
                  // Branch squashes the hazard: the dependent instruction is being flushed.
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (hazard) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end
            end
            StMemWait: begin
               // Branch/hazard ignored here; re-evaluated once back in RUN.
               if (!bus.mem_ready) begin
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                  memwb_bubble = 1'b1;
               end
            end
            default: begin
               {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
               memwb_bubble = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StRun;
         timer_q   <= 8'd0;
         mem_err_q <= 1'b0;
`ifdef STALL_PERF_EN
         stall_cycles <= 16'd0;
         flush_count  <= 16'd0;
`endif
      end else begin
         case (state_q)
            StRun: begin
               if (bus.mem_req && !bus.mem_ready) begin
                  state_q <= StMemWait;
                  timer_q <= 8'd1;
               end
            end
            StMemWait: begin
               if (bus.mem_ready) begin
                  state_q <= StRun;
                  timer_q <= 8'd0;
               end else if (timer_q == TimeoutVal) begin
                  // Set alongside the state so mem_err is high from the first ERR cycle.
                  state_q   <= StErr;
                  mem_err_q <= 1'b1;
               end else if (timer_q != 8'hFF) begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            default: begin
               state_q   <= StErr;
               mem_err_q <= 1'b1;
            end
         endcase
`ifdef STALL_PERF_EN
         if (!pc_en && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
         if (ifid_flush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
`endif
      end
   end

   assign bus.pc_en        = pc_en;
   assign bus.ifid_en      = ifid_en;
   assign bus.idex_en      = idex_en;
   assign bus.exmem_en     = exmem_en;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.idex_flush   = idex_flush;
   assign bus.memwb_bubble = memwb_bubble;
   assign bus.mem_err      = mem_err_q;

endmodule
